// File: rtl/scaling_coeff_lut_pipe_if.sv
// Request/result/config bundle for the scaling coefficient pipe.
// The master side issues requests and config writes; the slave side is the pipe.
interface scaling_coeff_lut_pipe_if #(
    parameter int unsigned COEFF_WIDTH       = 16,
    parameter int unsigned ERROR_SCALE_WIDTH = 32,
    parameter int unsigned NUM_CH            = 3
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [5:0]                   in_qp;
    logic [3:0]                   in_tshift;
    logic [CH_W-1:0]              in_ch;
    logic                         cfg_we;
    logic [CH_W-1:0]              cfg_ch;
    logic [4:0]                   cfg_bitdepth;
    logic                         out_valid;
    logic                         out_ready;
    logic [COEFF_WIDTH-1:0]       out_qcoef;
    logic [ERROR_SCALE_WIDTH-1:0] out_err_scale;
    logic [3:0]                   out_qp_per;
    logic [CH_W-1:0]              out_ch;
    logic                         out_sat;

    modport master (
        output in_valid, in_qp, in_tshift, in_ch, cfg_we, cfg_ch, cfg_bitdepth, out_ready,
        input  in_ready, out_valid, out_qcoef, out_err_scale, out_qp_per, out_ch, out_sat
    );

    modport slave (
        input  in_valid, in_qp, in_tshift, in_ch, cfg_we, cfg_ch, cfg_bitdepth, out_ready,
        output in_ready, out_valid, out_qcoef, out_err_scale, out_qp_per, out_ch, out_sat
    );
endinterface

// File: rtl/scaling_coeff_lut_pipe.sv
// Quant coefficient lookup plus error-scale computation via a bit-serial restoring divider.
// One request in flight; result held in DONE until the consumer takes it.
module scaling_coeff_lut_pipe #(
    parameter int unsigned COEFF_WIDTH       = 16,
    parameter int unsigned ERROR_SCALE_WIDTH = 32,
    parameter int unsigned ERR_FRAC_BITS     = 32,
    parameter int unsigned NUM_CH            = 3
) (
    input logic                     clk,
    input logic                     rst_n,
    scaling_coeff_lut_pipe_if.slave bus
);
    localparam int unsigned NUM_W    = ERR_FRAC_BITS + 16;
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W    = $clog2(NUM_W + 1);
    localparam int unsigned WIDE_W   = ((ERROR_SCALE_WIDTH > NUM_W) ? ERROR_SCALE_WIDTH : NUM_W) + 1;
    localparam int unsigned DVD_BASE = ERR_FRAC_BITS + 15;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [NUM_W-1:0]             dvd_q;
    logic [29:0]                  rem_q;
    logic [29:0]                  divisor_q;
    logic [15:0]                  qcoef_q;
    logic [3:0]                   qp_per_q;
    logic [CH_W-1:0]              ch_q;
    logic [4:0]                   bd_q;
    logic [4:0]                   bd_mem [NUM_CH];
    logic                         out_valid_q;
    logic [COEFF_WIDTH-1:0]       out_qcoef_q;
    logic [ERROR_SCALE_WIDTH-1:0] out_err_q;
    logic [3:0]                   out_qp_per_q;
    logic [CH_W-1:0]              out_ch_q;
    logic                         out_sat_q;

    logic [5:0]                   qp_c;
    logic [2:0]                   ts_c;
    logic [CH_W-1:0]              ch_c;
    logic [3:0]                   qp_per_c;
    logic [2:0]                   qp_rem_c;
    logic [15:0]                  coef_c;
    logic [29:0]                  divisor_c;
    logic [NUM_W-1:0]             dividend_c;
    logic [4:0]                   bd_sel;
    logic [4:0]                   cfg_bd_c;
    logic [30:0]                  rem_sh;
    logic                         rem_ge;
    logic [29:0]                  rem_sub;
    logic [NUM_W-1:0]             q_sh;
    logic [WIDE_W-1:0]            q_wide;
    logic                         sat_c;
    logic [ERROR_SCALE_WIDTH-1:0] err_c;

    always_comb begin
        qp_c     = (bus.in_qp > 6'd51) ? 6'd51 : bus.in_qp;
        ts_c     = (bus.in_tshift > 4'd7) ? 3'd7 : bus.in_tshift[2:0];
        ch_c     = (32'(bus.in_ch) >= NUM_CH) ? '0 : bus.in_ch;
        qp_per_c = 4'(qp_c / 6'd6);
        qp_rem_c = 3'(qp_c % 6'd6);
        case (qp_rem_c)
            3'd0:    coef_c = 16'd26214;
            3'd1:    coef_c = 16'd23302;
            3'd2:    coef_c = 16'd20560;
            3'd3:    coef_c = 16'd18396;
            3'd4:    coef_c = 16'd16384;
            3'd5:    coef_c = 16'd14564;
            default: coef_c = 16'd0;
        endcase
        // The square of the largest coefficient still fits in 30 bits.
        divisor_c  = 30'(coef_c) * 30'(coef_c);
        dividend_c = {{(NUM_W-1){1'b0}}, 1'b1} << (DVD_BASE - 32'(ts_c) * 2);
        bd_sel     = 5'd8;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(ch_c) == i) bd_sel = bd_mem[i];
        end
        cfg_bd_c = (bus.cfg_bitdepth < 5'd8)  ? 5'd8  :
                   (bus.cfg_bitdepth > 5'd16) ? 5'd16 : bus.cfg_bitdepth;
    end

    // Restoring step: remainder stays below the divisor, so 30 bits hold it between steps.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[NUM_W-1]};
        rem_ge  = rem_sh >= {1'b0, divisor_q};
        rem_sub = rem_sh[29:0] - divisor_q;
        q_sh    = dvd_q >> {(bd_q - 5'd8), 1'b0};
        q_wide  = {{(WIDE_W-NUM_W){1'b0}}, q_sh};
        sat_c   = (q_wide >> ERROR_SCALE_WIDTH) != '0;
        err_c   = sat_c ? '1 : q_wide[ERROR_SCALE_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) bd_mem[i] <= 5'd8;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.cfg_we && 32'(bus.cfg_ch) == i) bd_mem[i] <= cfg_bd_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dvd_q        <= '0;
            rem_q        <= '0;
            divisor_q    <= '0;
            qcoef_q      <= '0;
            qp_per_q     <= '0;
            ch_q         <= '0;
            bd_q         <= 5'd8;
            out_valid_q  <= 1'b0;
            out_qcoef_q  <= '0;
            out_err_q    <= '0;
            out_qp_per_q <= '0;
            out_ch_q     <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        qcoef_q   <= coef_c;
                        divisor_q <= divisor_c;
                        dvd_q     <= dividend_c;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        qp_per_q  <= qp_per_c;
                        ch_q      <= ch_c;
                        bd_q      <= bd_sel;
                        state_q   <= StCalc;
                    end
                end
                StCalc: begin
                    if (cnt_q != CNT_LAST) begin
                        rem_q <= rem_ge ? rem_sub : rem_sh[29:0];
                        dvd_q <= {dvd_q[NUM_W-2:0], rem_ge};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        out_qcoef_q  <= COEFF_WIDTH'(qcoef_q);
                        out_err_q    <= err_c;
                        out_sat_q    <= sat_c;
                        out_qp_per_q <= qp_per_q;
                        out_ch_q     <= ch_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready      = (state_q == StIdle);
    assign bus.out_valid     = out_valid_q;
    assign bus.out_qcoef     = out_qcoef_q;
    assign bus.out_err_scale = out_err_q;
    assign bus.out_qp_per    = out_qp_per_q;
    assign bus.out_ch        = out_ch_q;
    assign bus.out_sat       = out_sat_q;
endmodule

// File: tb/tb_scaling_coeff_lut_pipe.sv
// Bench: default-width pipe under random and directed requests, plus a 16-bit
// error-scale instance for the saturation path.
module tb_scaling_coeff_lut_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int bd_m [3];
    longint unsigned exp_qc, exp_err, exp_per, exp_ch, exp_sat;

    scaling_coeff_lut_pipe_if #(.COEFF_WIDTH(16), .ERROR_SCALE_WIDTH(32), .NUM_CH(3)) bus ();
    scaling_coeff_lut_pipe_if #(.COEFF_WIDTH(16), .ERROR_SCALE_WIDTH(16), .NUM_CH(3)) bus2 ();

    scaling_coeff_lut_pipe #(
        .COEFF_WIDTH(16), .ERROR_SCALE_WIDTH(32), .ERR_FRAC_BITS(32), .NUM_CH(3)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    scaling_coeff_lut_pipe #(
        .COEFF_WIDTH(16), .ERROR_SCALE_WIDTH(16), .ERR_FRAC_BITS(32), .NUM_CH(3)
    ) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_bd(input int bd);
        return (bd < 8) ? 8 : (bd > 16) ? 16 : bd;
    endfunction

    // Reference: error scale = floor(2^(47-2*tshift) / coef^2) / 4^(bitdepth-8), then saturate.
    task automatic model(input int which, input int qp, input int ts, input int ch);
        int qpc, tsc, chc, bd, esw;
        longint unsigned q, coef;
        int coefs [6] = '{26214, 23302, 20560, 18396, 16384, 14564};
        qpc = (qp > 51) ? 51 : qp;
        tsc = (ts > 7) ? 7 : ts;
        chc = (ch >= 3) ? 0 : ch;
        bd  = (which == 0) ? bd_m[chc] : 8;
        esw = (which == 0) ? 32 : 16;
        coef = longint'(coefs[qpc % 6]);
        q = (64'd1 << (47 - 2 * tsc)) / (coef * coef);
        q = q >> (2 * (bd - 8));
        exp_qc  = coef;
        exp_per = longint'(qpc / 6);
        exp_ch  = longint'(chc);
        if (q >= (64'd1 << esw)) begin
            exp_sat = 1;
            exp_err = (64'd1 << esw) - 1;
        end else begin
            exp_sat = 0;
            exp_err = q;
        end
    endtask

    task automatic cfg_write(input int ch, input int bd);
        bus.cfg_we       = 1'b1;
        bus.cfg_ch       = 2'(ch);
        bus.cfg_bitdepth = 5'(bd);
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        if (ch < 3) bd_m[ch] = clamp_bd(bd);
    endtask

    task automatic send(input int which, input int qp, input int ts, input int ch);
        model(which, qp, ts, ch);
        if (which == 0) begin
            bus.in_valid = 1'b1; bus.in_qp = 6'(qp); bus.in_tshift = 4'(ts); bus.in_ch = 2'(ch);
            check("accept_ready", bus.in_ready, 1);
        end else begin
            bus2.in_valid = 1'b1; bus2.in_qp = 6'(qp); bus2.in_tshift = 4'(ts); bus2.in_ch = 2'(ch);
            check("accept_ready2", bus2.in_ready, 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int which, input int lat, input string tag);
        int n = 0;
        logic got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk);
            #1;
            n++;
            got = (which == 0) ? bus.out_valid : bus2.out_valid;
        end
        check({tag, "_lat"}, longint'(n), longint'(lat));
        if (which == 0) begin
            check({tag, "_qcoef"}, bus.out_qcoef, exp_qc);
            check({tag, "_err"}, bus.out_err_scale, exp_err);
            check({tag, "_qpper"}, bus.out_qp_per, exp_per);
            check({tag, "_ch"}, bus.out_ch, exp_ch);
            check({tag, "_sat"}, bus.out_sat, exp_sat);
        end else begin
            check({tag, "_qcoef"}, bus2.out_qcoef, exp_qc);
            check({tag, "_err"}, bus2.out_err_scale, exp_err);
            check({tag, "_qpper"}, bus2.out_qp_per, exp_per);
            check({tag, "_ch"}, bus2.out_ch, exp_ch);
            check({tag, "_sat"}, bus2.out_sat, exp_sat);
        end
    endtask

    task automatic handshake(input int which);
        if (which == 0) bus.out_ready = 1'b1; else bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready  = 1'b0;
        bus2.out_ready = 1'b0;
        if (which == 0) begin
            check("hs_valid", bus.out_valid, 0);
            check("hs_ready", bus.in_ready, 1);
        end else begin
            check("hs_valid2", bus2.out_valid, 0);
            check("hs_ready2", bus2.in_ready, 1);
        end
    endtask

    initial begin
        int qp, ts, ch, lat, seen;
        longint unsigned hold_err, hold_qc;
        for (int i = 0; i < 3; i++) bd_m[i] = 8;
        bus.in_valid = 1'b0; bus.in_qp = '0; bus.in_tshift = '0; bus.in_ch = '0;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_bitdepth = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_qp = '0; bus2.in_tshift = '0; bus2.in_ch = '0;
        bus2.cfg_we = 1'b0; bus2.cfg_ch = '0; bus2.cfg_bitdepth = '0; bus2.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_qcoef", bus.out_qcoef, 0);
        check("rst_err", bus.out_err_scale, 0);
        check("rst_qpper", bus.out_qp_per, 0);
        check("rst_ch", bus.out_ch, 0);
        check("rst_sat", bus.out_sat, 0);
        check("rst_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // Basic known values.
        send(0, 0, 0, 0);
        wait_out(0, 49, "r029");
        check("r029_const", bus.out_err_scale, 204806);
        handshake(0);
        cfg_write(1, 10);
        send(0, 28, 2, 1);
        wait_out(0, 49, "r030");
        check("r030_const", bus.out_err_scale, 2048);
        handshake(0);
        send(0, 60, 12, 0);
        wait_out(0, 49, "r031");
        check("r031_const", bus.out_err_scale, 25);
        handshake(0);

        // Saturation on the narrow instance, then a non-saturating case there.
        send(1, 5, 0, 0);
        wait_out(1, 49, "r033");
        check("r033_const", bus2.out_err_scale, 16'hFFFF);
        check("r033_satc", bus2.out_sat, 1);
        handshake(1);
        send(1, 0, 2, 0);
        wait_out(1, 49, "nsat2");
        handshake(1);

        // Consumer stall with a competing request pending.
        send(0, 3, 1, 2);
        wait_out(0, 49, "stall");
        hold_err = exp_err;
        hold_qc  = exp_qc;
        bus.in_valid = 1'b1; bus.in_qp = 6'd10; bus.in_tshift = 4'd3; bus.in_ch = 2'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", bus.out_valid, 1);
            check("stall_inready", bus.in_ready, 0);
            check("stall_err", bus.out_err_scale, hold_err);
            check("stall_qcoef", bus.out_qcoef, hold_qc);
        end
        model(0, 10, 3, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("b2b_idle", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(0, 49, "b2b");
        handshake(0);

        // Random requests, with config writes before and during calculation.
        for (int it = 0; it < 16; it++) begin
            qp = $urandom_range(0, 63);
            ts = $urandom_range(0, 15);
            ch = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, 3), $urandom_range(0, 31));
            send(0, qp, ts, ch);
            lat = 49;
            if ($urandom_range(0, 1) == 1) begin
                cfg_write($urandom_range(0, 3), $urandom_range(0, 31));
                lat = 48;
            end
            wait_out(0, lat, "rand");
            handshake(0);
        end

        // Reset in the middle of a calculation.
        cfg_write(1, 12);
        cfg_write(2, 16);
        send(0, 7, 1, 1);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_ready", bus.in_ready, 1);
        check("mrst_err", bus.out_err_scale, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) bd_m[i] = 8;
        check("mrst_ready2", bus.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("mrst_novalid", longint'(seen), 0);
        send(0, 7, 1, 1);
        wait_out(0, 49, "mrst_ch1");
        handshake(0);
        send(0, 7, 1, 2);
        wait_out(0, 49, "mrst_ch2");
        handshake(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
